// File: rtl/ddr3_test_sequencer.sv
// Board-level DDR3 exerciser: debounced write/read buttons drive single-word or
// multi-word sweep commands to the DDR3 controller, with read-back compare and timeout.
module ddr3_test_sequencer #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned ROW_W           = 15,
  parameter int unsigned COL_W           = 10,
  parameter int unsigned BANK_W          = 3,
  parameter int unsigned NUM_WORDS       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              btn_wr,
  input  logic              btn_rd,
  input  logic              mode_sweep,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [ROW_W-1:0]  base_row,
  input  logic [COL_W-1:0]  base_col,
  input  logic [BANK_W-1:0] bank,
  output logic              ctrl_write,
  output logic              ctrl_read,
  output logic [ROW_W-1:0]  ctrl_row,
  output logic [COL_W-1:0]  ctrl_col,
  output logic [BANK_W-1:0] ctrl_bank,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic              ctrl_ack,
  input  logic              ctrl_done,
  input  logic [DATA_W-1:0] ctrl_rdata,
  output logic [DATA_W-1:0] led_data,
  output logic              busy,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_NEXT
  } state_e;

  // Button conditioning, bit 0 = write, bit 1 = read
  logic [1:0]            sync1_q, sync2_q, lvl_q, lvl_d, lvl_prev_q;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic                  wr_press, rd_press;

  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != lvl_q[b]) begin
        if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) lvl_d[b] = sync2_q[b];
        else                                           db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= {btn_rd, btn_wr};
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign wr_press = lvl_q[0] & ~lvl_prev_q[0];
  assign rd_press = lvl_q[1] & ~lvl_prev_q[1];

  // Sequence context and registered outputs
  state_e              state_q, state_d;
  logic                mode_q, mode_d, op_rd_q, op_rd_d;
  logic [DATA_W-1:0]   seed_q, seed_d, wdata_q, wdata_d, led_q, led_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                wr_q, wr_d, rd_q, rd_d, busy_q, busy_d;

  logic in_req, in_wait, cmpl, tmo_hit, last_word, more_words, wr_go, rd_go;

  assign in_req     = (state_q == S_WR_REQ)  || (state_q == S_RD_REQ);
  assign in_wait    = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
  assign cmpl       = (in_req && ctrl_ack && ctrl_done) || (in_wait && ctrl_done);
  assign tmo_hit    = (in_req || in_wait) && !cmpl && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign last_word  = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign more_words = mode_q && !last_word;
  assign wr_go      = (state_q == S_IDLE) && wr_press;
  assign rd_go      = (state_q == S_IDLE) && rd_press && !wr_press;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Completion beats timeout on the final cycle; ack alone moves REQ to WAIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_press)      state_d = S_WR_REQ;
        else if (rd_press) state_d = S_RD_REQ;
      end
      S_WR_REQ: begin
        if (cmpl)          state_d = S_NEXT;
        else if (tmo_hit)  state_d = S_IDLE;
        else if (ctrl_ack) state_d = S_WR_WAIT;
      end
      S_RD_REQ: begin
        if (cmpl)          state_d = S_NEXT;
        else if (tmo_hit)  state_d = S_IDLE;
        else if (ctrl_ack) state_d = S_RD_WAIT;
      end
      S_WR_WAIT, S_RD_WAIT: begin
        if (cmpl)         state_d = S_NEXT;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_NEXT: begin
        if (more_words) state_d = op_rd_q ? S_RD_REQ : S_WR_REQ;
        else            state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request lines follow the upcoming state so they are high exactly in REQ
  always_comb begin
    wr_d   = (state_d == S_WR_REQ);
    rd_d   = (state_d == S_RD_REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    mode_d    = mode_q;
    op_rd_d   = op_rd_q;
    seed_d    = seed_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    bank_d    = bank_q;
    led_d     = led_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    tmo_d     = ((state_q == S_IDLE) || (state_q == S_NEXT)) ? '0 : tmo_q + TMO_W'(1);

    if (wr_go || rd_go) begin
      mode_d  = mode_sweep;
      op_rd_d = rd_go;
      idx_d   = '0;
      row_d   = base_row;
      col_d   = base_col;
      bank_d  = bank;
      wdata_d = seed_q;
    end
    if (wr_go) begin
      seed_d    = sw_data;
      wdata_d   = sw_data;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end

    // wdata_q tracks seed+idx, serving as write data and read-back reference
    if ((state_q == S_NEXT) && more_words) begin
      idx_d   = idx_q + IDX_W'(1);
      col_d   = col_q + COL_W'(1);
      wdata_d = wdata_q + DATA_W'(1);
    end

    if (cmpl && op_rd_q) begin
      led_d = ctrl_rdata;
      if (ctrl_rdata != wdata_q) begin
        err_d     = 1'b1;
        err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      end
    end
    if (tmo_hit) begin
      err_d     = 1'b1;
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q    <= 1'b0;
      op_rd_q   <= 1'b0;
      seed_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      bank_q    <= '0;
      led_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      tmo_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      op_rd_q   <= op_rd_d;
      seed_q    <= seed_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      bank_q    <= bank_d;
      led_q     <= led_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      tmo_q     <= tmo_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
    end
  end

  assign ctrl_write = wr_q;
  assign ctrl_read  = rd_q;
  assign ctrl_row   = row_q;
  assign ctrl_col   = col_q;
  assign ctrl_bank  = bank_q;
  assign ctrl_wdata = wdata_q;
  assign led_data   = led_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ddr3_test_sequencer.sv
// Testbench for ddr3_test_sequencer: acts as the board and the DDR3 controller,
// checking commands and status against a word-list reference model.
module tb_ddr3_test_sequencer;
  localparam int unsigned DW = 8, RW = 15, CW = 10, BW = 3;
  localparam int unsigned NW = 4, DB = 8, TO = 16;

  logic clk = 1'b0;
  logic rst, btn_wr, btn_rd, mode_sweep, ctrl_ack, ctrl_done;
  logic [DW-1:0] sw_data, ctrl_rdata, ctrl_wdata, led_data;
  logic [RW-1:0] base_row, ctrl_row;
  logic [CW-1:0] base_col, ctrl_col;
  logic [BW-1:0] bank, ctrl_bank;
  logic ctrl_write, ctrl_read, busy, err;
  logic [7:0] err_count;

  int n_vec = 0, n_fail = 0;
  int wr_cmds = 0, rd_cmds = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;

  ddr3_test_sequencer #(
    .DATA_W(DW), .ROW_W(RW), .COL_W(CW), .BANK_W(BW),
    .NUM_WORDS(NW), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk), .RESET(rst), .btn_wr(btn_wr), .btn_rd(btn_rd),
    .mode_sweep(mode_sweep), .sw_data(sw_data), .base_row(base_row),
    .base_col(base_col), .bank(bank), .ctrl_write(ctrl_write),
    .ctrl_read(ctrl_read), .ctrl_row(ctrl_row), .ctrl_col(ctrl_col),
    .ctrl_bank(ctrl_bank), .ctrl_wdata(ctrl_wdata), .ctrl_ack(ctrl_ack),
    .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata), .led_data(led_data),
    .busy(busy), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Count request rising edges
  always @(posedge clk) begin
    #1;
    if (ctrl_write && !wr_prev) wr_cmds++;
    if (ctrl_read && !rd_prev) rd_cmds++;
    wr_prev = ctrl_write;
    rd_prev = ctrl_read;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  task automatic press(input bit w, input bit r);
    repeat (12) @(negedge clk);
    btn_wr = w;
    btn_rd = r;
    for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
    btn_wr = 1'b0;
    btn_rd = 1'b0;
  endtask

  // Controller side: wait for a request, ack after ack_dly, complete after done_dly
  task automatic serve(input int ack_dly, input int done_dly, input bit same,
                       input logic [DW-1:0] rdat, output bit found, output int waitc,
                       output bit o_wr, output logic [RW-1:0] o_row,
                       output logic [CW-1:0] o_col, output logic [BW-1:0] o_bank,
                       output logic [DW-1:0] o_wd, output int hi, output bit stable);
    found = 1'b0; waitc = 0; o_wr = 1'b0; o_row = '0; o_col = '0; o_bank = '0;
    o_wd = '0; hi = 0; stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ctrl_write || ctrl_read) begin
        found = 1'b1;
        break;
      end
      waitc++;
      @(negedge clk);
    end
    if (!found) return;
    o_wr = ctrl_write; o_row = ctrl_row; o_col = ctrl_col; o_bank = ctrl_bank;
    o_wd = ctrl_wdata; hi = 1;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      if (ctrl_write !== o_wr || ctrl_read !== !o_wr || ctrl_row !== o_row ||
          ctrl_col !== o_col || ctrl_bank !== o_bank || ctrl_wdata !== o_wd) stable = 1'b0;
      else hi++;
    end
    ctrl_ack = 1'b1;
    if (same) begin
      ctrl_done  = 1'b1;
      ctrl_rdata = rdat;
    end
    @(negedge clk);
    ctrl_ack  = 1'b0;
    ctrl_done = 1'b0;
    if (ctrl_write || ctrl_read) stable = 1'b0;
    if (!same) begin
      repeat (done_dly) @(negedge clk);
      ctrl_done  = 1'b1;
      ctrl_rdata = rdat;
      @(negedge clk);
      ctrl_done = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ctrl_write, ctrl_read, ctrl_row, ctrl_col, ctrl_bank, ctrl_wdata, led_data,
         busy, err, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got wr=%b rd=%b busy=%b err=%b cnt=%0d want all zero",
               ctrl_write, ctrl_read, busy, err, err_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_debounce;
    bit f, ow, st; int wc, hi, w0;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    mode_sweep = 1'b0; sw_data = 8'hA5; base_col = 10'd100; base_row = 15'd7; bank = 3'd1;
    w0 = wr_cmds;
    for (int k = 0; k < 5; k++) begin
      btn_wr = 1'b1; repeat (3) @(negedge clk);
      btn_wr = 1'b0; repeat (2) @(negedge clk);
    end
    n_vec++;
    if (wr_cmds - w0 != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_ignored got cmds=%0d busy=%b want 0 0", wr_cmds - w0, busy);
    end
    btn_wr = 1'b1;
    serve(1, 1, 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
    btn_wr = 1'b0;
    n_vec++;
    if ({f, ow} !== 2'b11 || ocol !== 10'd100 || owd !== 8'hA5) begin
      n_fail++;
      $display("FAIL debounce_write got found=%b wr=%b col=%0d data=%h want 1 1 100 a5",
               f, ow, ocol, owd);
    end
    repeat (30) @(negedge clk);
    n_vec++;
    if (wr_cmds - w0 != 1) begin
      n_fail++;
      $display("FAIL debounce_count got %0d want 1", wr_cmds - w0);
    end
  endtask

  task automatic test_single;
    bit f, ow, st; int wc, hi;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    mode_sweep = 1'b0; sw_data = 8'h3C; base_col = 10'd5; base_row = 15'h1234; bank = 3'd2;
    press(1, 0);
    serve(0, 1, 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
    n_vec++;
    if ({f, ow} !== 2'b11 || owd !== 8'h3C || ocol !== 10'd5 || orow !== 15'h1234 || obk !== 3'd2) begin
      n_fail++;
      $display("FAIL single_write got wr=%b data=%h col=%0d row=%h bank=%0d want 1 3c 5 1234 2",
               ow, owd, ocol, orow, obk);
    end
    press(0, 1);
    serve(0, 1, 0, 8'h3C, f, wc, ow, orow, ocol, obk, owd, hi, st);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({f, ow} !== 2'b10 || led_data !== 8'h3C || err !== 1'b0 || err_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_ok got rd=%b led=%h err=%b cnt=%0d busy=%b want 1 3c 0 0 0",
               f & !ow, led_data, err, err_count, busy);
    end
    press(0, 1);
    serve(0, 1, 0, 8'h3D, f, wc, ow, orow, ocol, obk, owd, hi, st);
    repeat (2) @(negedge clk);
    n_vec++;
    if (led_data !== 8'h3D || err !== 1'b1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL single_read_bad got led=%h err=%b cnt=%0d want 3d 1 1", led_data, err, err_count);
    end
  endtask

  task automatic test_sweep;
    bit f, ow, st; int wc, hi;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    int ec [4]; logic [DW-1:0] ed [4];
    ec = '{1022, 1023, 0, 1};
    ed = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    mode_sweep = 1'b1; sw_data = 8'hFE; base_col = 10'd1022; base_row = 15'd99; bank = 3'd5;
    press(1, 0);
    for (int i = 0; i < 4; i++) begin
      serve(i, 2 - (i % 3), 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
      n_vec++;
      if ({f, ow} !== 2'b11 || ocol !== 10'(ec[i]) || owd !== ed[i] || (i > 0 && wc != 1)) begin
        n_fail++;
        $display("FAIL sweep_write[%0d] got col=%0d data=%h gap=%0d want %0d %h 1",
                 i, ocol, owd, wc, ec[i], ed[i]);
      end
    end
    press(0, 1);
    for (int i = 0; i < 4; i++) begin
      serve(0, 0, 0, ed[i], f, wc, ow, orow, ocol, obk, owd, hi, st);
      n_vec++;
      if ({f, ow} !== 2'b10 || ocol !== 10'(ec[i])) begin
        n_fail++;
        $display("FAIL sweep_read[%0d] got found=%b wr=%b col=%0d want 1 0 %0d", i, f, ow, ocol, ec[i]);
      end
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (err_count !== 8'd0 || err !== 1'b0 || led_data !== 8'h01) begin
      n_fail++;
      $display("FAIL sweep_status got cnt=%0d err=%b led=%h want 0 0 01", err_count, err, led_data);
    end
  endtask

  task automatic test_ack_delay;
    bit f, ow, st; int wc, hi;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    mode_sweep = 1'b0; sw_data = 8'h81; base_col = 10'd300;
    press(1, 0);
    serve(3, 1, 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
    n_vec++;
    if (!f || hi != 4 || !st || owd !== 8'h81) begin
      n_fail++;
      $display("FAIL ack_delay got found=%b high=%0d stable=%b data=%h want 1 4 1 81", f, hi, st, owd);
    end
    mode_sweep = 1'b1;
    press(1, 0);
    for (int i = 0; i < 4; i++) begin
      serve(0, 0, 1, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
      n_vec++;
      if (!f || !st || (i > 0 && wc != 1) || ocol !== 10'(300 + i)) begin
        n_fail++;
        $display("FAIL ack_done_same[%0d] got found=%b stable=%b gap=%0d col=%0d want 1 1 1 %0d",
                 i, f, st, wc, ocol, 300 + i);
      end
    end
  endtask

  task automatic test_timeout;
    bit f, ow, st; int wc, hi, h;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    mode_sweep = 1'b1; sw_data = 8'h5A; base_col = 10'd40;
    press(1, 0);
    h = 0;
    for (int i = 0; i < 100 && ctrl_write; i++) begin
      h++;
      @(negedge clk);
    end
    n_vec++;
    if (h != TO || err !== 1'b1 || err_count !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout got high=%0d err=%b cnt=%0d busy=%b want %0d 1 1 0", h, err, err_count, busy, TO);
    end
    mode_sweep = 1'b0;
    press(0, 1);
    serve(0, 0, 0, 8'h5A, f, wc, ow, orow, ocol, obk, owd, hi, st);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({f, ow} !== 2'b10 || err_count !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_timeout got found=%b wr=%b cnt=%0d busy=%b want 1 0 1 0", f, ow, err_count, busy);
    end
  endtask

  task automatic test_random;
    bit f, ow, st; int wc, hi, n;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    logic [DW-1:0] m_seed, m_led, ex, rd; int m_cnt; bit m_err;
    logic [RW-1:0] r_row; logic [CW-1:0] r_col, e_col; logic [BW-1:0] r_bank;
    for (int it = 0; it < 6; it++) begin
      m_seed = 8'($urandom);
      r_col  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(1018, 1023)) : 10'($urandom);
      r_row  = 15'($urandom);
      r_bank = 3'($urandom);
      mode_sweep = 1'($urandom_range(0, 1));
      n = mode_sweep ? NW : 1;
      sw_data = m_seed; base_col = r_col; base_row = r_row; bank = r_bank;
      m_err = 1'b0; m_cnt = 0; m_led = led_data;
      press(1, 0);
      for (int i = 0; i < n; i++) begin
        serve($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'h00,
              f, wc, ow, orow, ocol, obk, owd, hi, st);
        e_col = 10'((int'(r_col) + i) % 1024);
        n_vec++;
        if ({f, ow} !== 2'b11 || ocol !== e_col || owd !== 8'((int'(m_seed) + i) % 256) ||
            orow !== r_row || obk !== r_bank || !st) begin
          n_fail++;
          $display("FAIL rand_write[%0d.%0d] got col=%0d data=%h row=%h bank=%0d want %0d %h %h %0d",
                   it, i, ocol, owd, orow, obk, e_col, 8'((int'(m_seed) + i) % 256), r_row, r_bank);
        end
      end
      press(0, 1);
      for (int i = 0; i < n; i++) begin
        ex = 8'((int'(m_seed) + i) % 256);
        rd = ($urandom_range(0, 3) == 0) ? (ex ^ 8'(1 << $urandom_range(0, 7))) : ex;
        if (rd != ex) begin
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        m_led = rd;
        serve($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd,
              f, wc, ow, orow, ocol, obk, owd, hi, st);
        e_col = 10'((int'(r_col) + i) % 1024);
        n_vec++;
        if ({f, ow} !== 2'b10 || ocol !== e_col) begin
          n_fail++;
          $display("FAIL rand_read[%0d.%0d] got found=%b wr=%b col=%0d want 1 0 %0d", it, i, f, ow, ocol, e_col);
        end
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if (led_data !== m_led || err !== m_err || err_count !== 8'(m_cnt) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_status[%0d] got led=%h err=%b cnt=%0d busy=%b want %h %b %0d 0",
                 it, led_data, err, err_count, busy, m_led, m_err, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit f, ow, st; int wc, hi;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    mode_sweep = 1'b1; sw_data = 8'h40; base_col = 10'd8; base_row = 15'd3; bank = 3'd6;
    press(1, 0);
    serve(0, 0, 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
    serve(0, 0, 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
    for (int i = 0; i < 10 && !ctrl_write; i++) @(negedge clk);
    ctrl_ack = 1'b1;
    @(negedge clk);
    ctrl_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ctrl_write, ctrl_read, ctrl_row, ctrl_col, ctrl_bank, ctrl_wdata, led_data,
         busy, err, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got wr=%b col=%0d data=%h busy=%b want all zero",
               ctrl_write, ctrl_col, ctrl_wdata, busy);
    end
    rst = 1'b0;
    mode_sweep = 1'b0;
    press(0, 1);
    serve(0, 0, 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({f, ow} !== 2'b10 || err !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL read_seed0_ok got found=%b err=%b cnt=%0d want 1 0 0", f, err, err_count);
    end
    press(0, 1);
    serve(0, 0, 0, 8'h05, f, wc, ow, orow, ocol, obk, owd, hi, st);
    repeat (2) @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || err_count !== 8'd1 || led_data !== 8'h05) begin
      n_fail++;
      $display("FAIL read_seed0_bad got err=%b cnt=%0d led=%h want 1 1 05", err, err_count, led_data);
    end
  endtask

  task automatic test_simultaneous;
    bit f, ow, st; int wc, hi, w0, r0;
    logic [RW-1:0] orow; logic [CW-1:0] ocol; logic [BW-1:0] obk; logic [DW-1:0] owd;
    mode_sweep = 1'b0; sw_data = 8'h77; base_col = 10'd512;
    repeat (12) @(negedge clk);
    w0 = wr_cmds; r0 = rd_cmds;
    press(1, 1);
    serve(0, 0, 0, 8'h00, f, wc, ow, orow, ocol, obk, owd, hi, st);
    repeat (40) @(negedge clk);
    n_vec++;
    if ({f, ow} !== 2'b11 || owd !== 8'h77 || wr_cmds - w0 != 1 || rd_cmds - r0 != 0) begin
      n_fail++;
      $display("FAIL simultaneous got wr=%b data=%h wcmds=%0d rcmds=%0d want 1 77 1 0",
               ow, owd, wr_cmds - w0, rd_cmds - r0);
    end
  endtask

  initial begin
    rst = 1'b1; btn_wr = 1'b0; btn_rd = 1'b0; mode_sweep = 1'b0; sw_data = '0;
    base_row = '0; base_col = '0; bank = '0; ctrl_ack = 1'b0; ctrl_done = 1'b0; ctrl_rdata = '0;
    test_reset;
    test_debounce;
    test_single;
    test_sweep;
    test_ack_delay;
    test_timeout;
    test_random;
    test_reset_mid;
    test_simultaneous;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
